// File: rtl/dunshift.sv
// Parallel-to-serial lane unloader: captures DEPTH lanes of DW bits and emits them one word per transfer.
// Latency: first word on dout one cycle after capture; later words follow back-to-back with no bubble.
// Backpressure: dout/dout_last hold while dout_ready is low; din_ready is low for the whole burst.
//
// Ports:
//   clk, sys_rst       - clock, asynchronous active-high reset
//   dir, l_k_0         - unload order (00 drop, 01 POS, 10 NEG, 11 NEW) and NEW lane-pair select, sampled at capture
//   din/din_valid/din_ready     - parallel lane vector handshake (lane i = din[i*DW +: DW])
//   dout/dout_valid/dout_ready  - serial word handshake; dout_last flags the final word of a burst
module dunshift #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic [1:0]          dir,
  input  logic                l_k_0,
  input  logic [DW*DEPTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              state;
  logic [DW*DEPTH-1:0] lane_buf;
  logic [IW-1:0]       idx;        // lane currently shown on dout
  logic                down;       // 1: walk lanes downward, 0: upward
  logic [CW-1:0]       cnt;        // words still to transfer, including the one on dout

  logic [IW-1:0]       start_idx;
  logic [CW-1:0]       start_cnt;
  logic                start_down;
  logic [IW-1:0]       next_idx;

  // Decode the capture-time controls into first lane, walk direction and burst length.
  // Every order except NEG walks downward, so NEW is just a 2-word descending walk
  // starting at lane 1 or lane 3.
  always_comb begin
    start_idx  = '0;
    start_cnt  = CW'(DEPTH);
    start_down = 1'b1;
    case (dir)
      2'b01: begin
        start_idx  = IW'(DEPTH - 1);
      end
      2'b10: begin
        start_idx  = '0;
        start_down = 1'b0;
      end
      2'b11: begin
        start_idx  = l_k_0 ? IW'(1) : IW'(3);
        start_cnt  = CW'(2);
      end
      default: begin
        start_idx  = '0;
      end
    endcase
  end

  // Only consumed while more words remain, so it never indexes past the burst.
  assign next_idx  = down ? (idx - IW'(1)) : (idx + IW'(1));

  assign din_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      lane_buf   <= '0;
      idx        <= '0;
      down       <= 1'b0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (din_valid) begin
            lane_buf <= din;
            // dir == 00 consumes the beat without starting a burst.
            if (dir != 2'b00) begin
              state      <= S_SEND;
              idx        <= start_idx;
              down       <= start_down;
              cnt        <= start_cnt;
              dout       <= din[start_idx*DW +: DW];
              dout_valid <= 1'b1;
              dout_last  <= (start_cnt == CW'(1));
            end
          end
        end
        S_SEND: begin
          if (dout_ready) begin
            if (cnt == CW'(1)) begin
              state      <= S_IDLE;
              cnt        <= '0;
              dout       <= '0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
            end else begin
              cnt       <= cnt - CW'(1);
              idx       <= next_idx;
              dout      <= lane_buf[next_idx*DW +: DW];
              dout_last <= (cnt == CW'(2));
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dunshift.sv
module tb_dunshift;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                sys_rst;
  logic [1:0]          dir;
  logic                l_k_0;
  logic [DW*DEPTH-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic [DW-1:0]       dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                dout_last;

  always #5 clk = ~clk;

  dunshift #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .dir        (dir),
    .l_k_0      (l_k_0),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  logic [DW-1:0] exp_q[$];   // model: words still owed by the current burst
  logic [DW:0]   obs_q[$];   // observed transfers as {last, word}

  localparam logic [DW*DEPTH-1:0] D = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input logic [DW*DEPTH-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Compare process: every cycle outside reset the outputs must match the model.
  always @(negedge clk) begin
    if (run && !sys_rst) begin
      logic          e_vld;
      logic [DW-1:0] e_dout;
      e_vld  = (exp_q.size() != 0);
      e_dout = e_vld ? exp_q[0] : '0;
      chk("din_ready",  {31'b0, din_ready},  {31'b0, !e_vld});
      chk("dout_valid", {31'b0, dout_valid}, {31'b0, e_vld});
      chk("dout",       {16'b0, dout},       {16'b0, e_dout});
      chk("dout_last",  {31'b0, dout_last},  {31'b0, exp_q.size() == 1});
    end
  end

  // One cycle: drive inputs after the falling edge, log any transfer, then advance the model.
  task automatic step(input bit v, input logic [1:0] d, input bit k,
                      input logic [DW*DEPTH-1:0] data, input bit rdy);
    @(negedge clk);
    #1;
    din_valid  = v;
    dir        = d;
    l_k_0      = k;
    din        = data;
    dout_ready = rdy;
    #1;
    if (dout_valid && dout_ready) obs_q.push_back({dout_last, dout});
    @(posedge clk);
    if (exp_q.size() == 0) begin
      if (v) begin
        case (d)
          2'b01: for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(lane(data, i));
          2'b10: for (int i = 0; i < DEPTH; i++) exp_q.push_back(lane(data, i));
          2'b11: begin
            exp_q.push_back(lane(data, k ? 1 : 3));
            exp_q.push_back(lane(data, k ? 0 : 2));
          end
          default: ;
        endcase
      end
    end else if (rdy) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, '0, 1'b1);
  endtask

  task automatic check_obs(input string nm, input int n,
                           input logic [DW:0] e0, input logic [DW:0] e1,
                           input logic [DW:0] e2, input logic [DW:0] e3);
    logic [DW:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < obs_q.size()) chk($sformatf("%s_word%0d", nm, i), {15'b0, obs_q[i]}, {15'b0, e[i]});
    obs_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    sys_rst   = 1'b1;
    din_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst    = 1'b1;
    dir        = 2'b00;
    l_k_0      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dout",       {16'b0, dout},       32'h0);
    chk("rst_dout_valid", {31'b0, dout_valid}, 32'h0);
    chk("rst_dout_last",  {31'b0, dout_last},  32'h0);
    chk("rst_din_ready",  {31'b0, din_ready},  32'h1);
    @(negedge clk);
    #1;
    sys_rst = 1'b0;
    run     = 1'b1;

    // POS, free-flowing
    step(1'b1, 2'b01, 1'b0, D, 1'b1);
    idle(4);
    #2;
    chk("pos_din_ready_after", {31'b0, din_ready}, 32'h1);
    check_obs("pos", 4, 17'h0_4444, 17'h0_3333, 17'h0_2222, 17'h1_1111);

    // NEG
    step(1'b1, 2'b10, 1'b0, D, 1'b1);
    idle(5);
    check_obs("neg", 4, 17'h0_1111, 17'h0_2222, 17'h0_3333, 17'h1_4444);

    // NEW, both lane pairs; controls change right after capture
    step(1'b1, 2'b11, 1'b1, D, 1'b1);
    idle(3);
    check_obs("new1", 2, 17'h0_2222, 17'h1_1111, 17'h0, 17'h0);
    step(1'b1, 2'b11, 1'b0, D, 1'b1);
    step(1'b1, 2'b10, 1'b1, ~D, 1'b1);
    idle(2);
    check_obs("new0", 2, 17'h0_4444, 17'h1_3333, 17'h0, 17'h0);

    // POS with 3 stalled cycles on 3333
    step(1'b1, 2'b01, 1'b0, D, 1'b1);
    step(1'b0, 2'b00, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b10, 1'b0, ~D, 1'b0);
      #2;
      chk("stall_hold", {16'b0, dout}, 32'h3333);
    end
    idle(4);
    check_obs("stall", 4, 17'h0_4444, 17'h0_3333, 17'h0_2222, 17'h1_1111);

    // NEG aborted by reset while 2222 is shown
    step(1'b1, 2'b10, 1'b0, D, 1'b1);
    step(1'b0, 2'b00, 1'b0, '0, 1'b1);
    #2;
    chk("abort_pre", {16'b0, dout}, 32'h2222);
    @(negedge clk);
    #1;
    sys_rst   = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("abort_dout",       {16'b0, dout},       32'h0);
    chk("abort_dout_valid", {31'b0, dout_valid}, 32'h0);
    chk("abort_din_ready",  {31'b0, din_ready},  32'h1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    sys_rst = 1'b0;
    idle(5);
    check_obs("abort", 1, 17'h0_1111, 17'h0, 17'h0, 17'h0);

    // dir = 00 drops the beat; next POS capture still starts at lane 3
    step(1'b1, 2'b00, 1'b0, ~D, 1'b1);
    #2;
    chk("drop_dout_valid", {31'b0, dout_valid}, 32'h0);
    chk("drop_din_ready",  {31'b0, din_ready},  32'h1);
    step(1'b1, 2'b01, 1'b0, D, 1'b1);
    idle(4);
    check_obs("drop_pos", 4, 17'h0_4444, 17'h0_3333, 17'h0_2222, 17'h1_1111);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      end
      obs_q.delete();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dunshift.md
DUNSHIFT -- requirements
Module: dunshift

Interface
REQ-001 Parameter DW, default 16: lane word width in bits.
REQ-002 Parameter DEPTH, default 4: number of lanes; DEPTH >= 4 SHALL hold, and DIR_NEW mode uses lanes 0..3 only.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous and active-high.
REQ-005 dir  input  2  unload order, sampled at capture: 00 IDLE, 01 POS, 10 NEG, 11 NEW.
REQ-006 l_k_0  input  1  DIR_NEW lane-pair select, sampled at capture.
REQ-007 din  input  DW*DEPTH  parallel lane vector; lane i = din[i*DW +: DW].
REQ-008 din_valid  input  1  din/dir/l_k_0 are valid this cycle.
REQ-009 din_ready  output  1  block can capture this cycle.
REQ-010 dout  output  DW  serial output word.
REQ-011 dout_valid  output  1  dout holds a valid word.
REQ-012 dout_ready  input  1  downstream accepts dout this cycle.
REQ-013 dout_last  output  1  current dout word is the final word of the burst.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-015 din_ready SHALL equal (state == IDLE); it is combinational from state.
REQ-016 A capture SHALL occur on a rising edge where din_valid && din_ready; din is copied to an internal DW*DEPTH buffer.
REQ-017 At capture with dir == 00, the beat SHALL be consumed and dropped; the state SHALL remain IDLE and dout_valid SHALL stay 0.
REQ-018 At capture with dir != 00, the state SHALL go to SEND, and the first word SHALL be on dout with dout_valid = 1 in the next cycle (1-cycle latency).
REQ-019 In POS order, the burst SHALL be DEPTH words: lane DEPTH-1 first, descending to lane 0.
REQ-020 In NEG order, the burst SHALL be DEPTH words: lane 0 first, ascending to lane DEPTH-1.
REQ-021 In NEW order with l_k_0 = 1, the burst SHALL be 2 words: lane 1, then lane 0.
REQ-022 In NEW order with l_k_0 = 0, the burst SHALL be 2 words: lane 3, then lane 2.
REQ-023 A word SHALL transfer on a rising edge where dout_valid && dout_ready; the next word SHALL appear in the following cycle with no bubble.
REQ-024 While dout_valid && !dout_ready, dout and dout_last SHALL hold stable.
REQ-025 A remaining-word counter of width clog2(DEPTH+1) SHALL be loaded at capture with DEPTH (POS/NEG) or 2 (NEW).
REQ-026 The counter SHALL decrement on each transfer.
REQ-027 dout_last SHALL be 1 when the counter equals 1 and dout_valid = 1, and 0 otherwise.
REQ-028 The transfer of the dout_last word SHALL return the FSM to IDLE, with dout_valid = 0 and din_ready = 1 in the next cycle.
REQ-029 The minimum spacing between captures SHALL be burst length + 1 cycles.
REQ-030 din_valid while in SEND SHALL be ignored; the buffer SHALL not change mid-burst.
REQ-031 dout SHALL be 0 whenever dout_valid = 0.
REQ-032 Changes to dir or l_k_0 after capture SHALL NOT affect the ongoing burst.

Reset
REQ-033 While sys_rst = 1 the block SHALL be forced asynchronously to: state IDLE, buffer 0, counter 0, dout 0, dout_valid 0, dout_last 0, din_ready 1.
REQ-034 Assertion of sys_rst mid-burst SHALL abort the burst immediately; no remaining words are emitted after release.
REQ-035 The first capture after reset SHALL be accepted on the first rising edge with sys_rst = 0 and din_valid = 1.

Verification
(DW = 16, DEPTH = 4, din = {16'h4444, 16'h3333, 16'h2222, 16'h1111} as lanes 3..0.)
REQ-036 POS, dout_ready = 1 -> dout 4444, 3333, 2222, 1111 on consecutive cycles; dout_last only on 1111; din_ready = 1 on the cycle after 1111.
REQ-037 NEG -> dout 1111, 2222, 3333, 4444; dout_last on 4444.
REQ-038 NEW with l_k_0 = 1 -> 2222, 1111; NEW with l_k_0 = 0 -> 4444, 3333; each burst is 2 words with dout_last on the second.
REQ-039 POS, dout_ready held low for 3 cycles while 3333 is shown -> 3333 held 4 cycles total, then 2222, 1111; no word lost or duplicated.
REQ-040 sys_rst pulsed while 2222 is shown in NEG -> dout = 0, dout_valid = 0, din_ready = 1 at once; no 3333 or 4444 after release.
REQ-041 Capture with dir = 00 -> dout_valid stays 0, din_ready stays 1; a following POS capture still yields 4444 first.
